// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester and controller signals of the two-port SDRAM arbiter
interface sdram_port_arbiter_if #(parameter int ADDR_W = 25, parameter int DATA_W = 16);
  logic iM0_REQ, iM1_REQ, iM0_WR, iM1_WR;
  logic [ADDR_W-1:0] iM0_ADDR, iM1_ADDR;
  logic [DATA_W-1:0] iM0_WDATA, iM1_WDATA;
  logic oM0_ACK, oM1_ACK, oM0_RVALID, oM1_RVALID;
  logic [DATA_W-1:0] oM0_RDATA, oM1_RDATA;
  logic oWRITE, oREAD;
  logic [ADDR_W-1:0] oADDR;
  logic [DATA_W-1:0] oWDATA;
  logic iWAIT_REQ, iRDVAL;
  logic [DATA_W-1:0] iRDATA;
  logic [1:0] oGRANT;
  logic oERR;
  modport slave (
    input iM0_REQ, iM1_REQ, iM0_WR, iM1_WR, iM0_ADDR, iM1_ADDR, iM0_WDATA, iM1_WDATA,
    input iWAIT_REQ, iRDVAL, iRDATA,
    output oM0_ACK, oM1_ACK, oM0_RVALID, oM1_RVALID, oM0_RDATA, oM1_RDATA,
    output oWRITE, oREAD, oADDR, oWDATA, oGRANT, oERR
  );
  modport master (
    output iM0_REQ, iM1_REQ, iM0_WR, iM1_WR, iM0_ADDR, iM1_ADDR, iM0_WDATA, iM1_WDATA,
    output iWAIT_REQ, iRDVAL, iRDATA,
    input oM0_ACK, oM1_ACK, oM0_RVALID, oM1_RVALID, oM0_RDATA, oM1_RDATA,
    input oWRITE, oREAD, oADDR, oWDATA, oGRANT, oERR
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin burst-limited sharing of one SDRAM command port between two
// requesters, with an owner-tag FIFO steering read data back to the issuing port
module sdram_port_arbiter #(
  parameter int ADDR_W = 25, DATA_W = 16, BURST_MAX = 8, TAG_DEPTH = 4
) (
  input logic iCLK,
  input logic iRST_n,
  sdram_port_arbiter_if.slave bus
);
  localparam int PW = TAG_DEPTH > 1 ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] TAG_FULL = CW'(TAG_DEPTH);
  localparam logic [BW-1:0] BURST_END = BW'(BURST_MAX);
  typedef enum logic [1:0] {IDLE, ISSUE, ACKED} state_t;
  state_t state_q, state_d;
  logic write_q, write_d, read_q, read_d, last_q, last_d, err_q, err_d;
  logic [1:0] grant_q, grant_d, ack_q, ack_d, rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TAG_DEPTH-1:0] tags_q, tags_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic elig0, elig1, pick, sel_wr, owner, accept, push, pop, head;
  always_comb begin
    elig0 = bus.iM0_REQ && (bus.iM0_WR || cnt_q < TAG_FULL);
    elig1 = bus.iM1_REQ && (bus.iM1_WR || cnt_q < TAG_FULL);
    // a zero burst count only occurs after reset, where there is no owner to keep
    pick = (elig0 && elig1) ? ((burst_q != '0 && burst_q < BURST_END) ? last_q : !last_q) : elig1;
    sel_wr = pick ? bus.iM1_WR : bus.iM0_WR;
    owner = grant_q[1];
    accept = state_q == ISSUE && !bus.iWAIT_REQ;
    push = accept && read_q;
    pop = bus.iRDVAL && cnt_q != '0;
    head = tags_q[rp_q];
    state_d = state_q;
    write_d = write_q;
    read_d = read_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    last_d = last_q;
    burst_d = burst_q;
    ack_d = '0;
    if (state_q == IDLE && (elig0 || elig1)) begin
      state_d = ISSUE;
      write_d = sel_wr;
      read_d = !sel_wr;
      addr_d = pick ? bus.iM1_ADDR : bus.iM0_ADDR;
      wdata_d = pick ? bus.iM1_WDATA : bus.iM0_WDATA;
      grant_d = pick ? 2'b10 : 2'b01;
      burst_d = (pick != last_q || burst_q == BURST_END) ? '0 : burst_q;
      last_d = pick;
    end else if (accept) begin
      state_d = ACKED;
      write_d = 1'b0;
      read_d = 1'b0;
      grant_d = '0;
      ack_d = owner ? 2'b10 : 2'b01;
      burst_d = burst_q + 1'b1;
    end else if (state_q == ACKED) begin
      state_d = IDLE;
    end
    tags_d = tags_q;
    if (push) tags_d[wp_q] = owner;
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    rvalid_d = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
    rdata0_d = (pop && !head) ? bus.iRDATA : rdata0_q;
    rdata1_d = (pop && head) ? bus.iRDATA : rdata1_q;
    err_d = err_q || (bus.iRDVAL && cnt_q == '0);
  end
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      read_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      grant_q <= '0;
      last_q <= 1'b1;
      burst_q <= '0;
      ack_q <= '0;
      tags_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      read_q <= read_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      last_q <= last_d;
      burst_q <= burst_d;
      ack_q <= ack_d;
      tags_q <= tags_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q <= err_d;
    end
  end
  assign bus.oWRITE = write_q;
  assign bus.oREAD = read_q;
  assign bus.oADDR = addr_q;
  assign bus.oWDATA = wdata_q;
  assign bus.oGRANT = grant_q;
  assign bus.oM0_ACK = ack_q[0];
  assign bus.oM1_ACK = ack_q[1];
  assign bus.oM0_RVALID = rvalid_q[0];
  assign bus.oM1_RVALID = rvalid_q[1];
  assign bus.oM0_RDATA = rdata0_q;
  assign bus.oM1_RDATA = rdata1_q;
  assign bus.oERR = err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed and randomized scoreboard bench for the two-port SDRAM arbiter
module tb_sdram_port_arbiter;
  localparam int AW = 25, DW = 16;
  typedef struct packed {logic wr; logic [AW-1:0] a; logic [DW-1:0] d;} cmd_t;
  typedef struct packed {logic p; logic [DW-1:0] d;} rd_t;
  logic iCLK = 0, iRST_n = 1;
  always #5 iCLK = ~iCLK;
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(8), .TAG_DEPTH(4)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .bus(bus));
  logic req[2], wr[2], wreq = 0, rdval = 0;
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2], rdat = '0;
  logic [1:0] ack, rv;
  assign bus.iM0_REQ = req[0];
  assign bus.iM1_REQ = req[1];
  assign bus.iM0_WR = wr[0];
  assign bus.iM1_WR = wr[1];
  assign bus.iM0_ADDR = addr[0];
  assign bus.iM1_ADDR = addr[1];
  assign bus.iM0_WDATA = wdata[0];
  assign bus.iM1_WDATA = wdata[1];
  assign bus.iWAIT_REQ = wreq;
  assign bus.iRDVAL = rdval;
  assign bus.iRDATA = rdat;
  assign ack = {bus.oM1_ACK, bus.oM0_ACK};
  assign rv = {bus.oM1_RVALID, bus.oM0_RVALID};
  int checks = 0, passes = 0, rd_acc = 0, acc_cnt[2] = '{0, 0};
  cmd_t exp_cmd[2][$];
  logic own_q[$];
  rd_t exp_rd[$];
  bit glog[$];
  logic [1:0] exp_ack = '0, exp_rv = '0;
  logic exp_err = 0, p_hold = 0, mp;
  logic [DW-1:0] mdl_rdata[2];
  logic [AW+DW+3:0] p_snap;
  cmd_t c;
  rd_t e;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // scoreboard monitor: compares this cycle's outputs, then records expectations for the next
  always @(negedge iCLK) begin
    if (!iRST_n) begin
      exp_cmd[0].delete();
      exp_cmd[1].delete();
      own_q.delete();
      exp_rd.delete();
      mdl_rdata = '{'0, '0};
      exp_ack = '0;
      exp_rv = '0;
      exp_err = 0;
      p_hold = 0;
    end else begin
      chk("ack", ack, exp_ack);
      chk("rvalid", rv, exp_rv);
      if (rv != '0 && exp_rd.size() != 0) begin
        e = exp_rd.pop_front();
        mdl_rdata[e.p] = e.d;
      end
      chk("m0_rdata", bus.oM0_RDATA, mdl_rdata[0]);
      chk("m1_rdata", bus.oM1_RDATA, mdl_rdata[1]);
      chk("err", bus.oERR, exp_err);
      chk("strobe_excl", bus.oWRITE && bus.oREAD, 0);
      if (p_hold) chk("stall_hold", {bus.oWRITE, bus.oREAD, bus.oGRANT, bus.oADDR, bus.oWDATA}, p_snap);
      exp_ack = '0;
      exp_rv = '0;
      if (bus.iRDVAL) begin
        if (own_q.size() == 0) exp_err = 1;
        else begin
          mp = own_q.pop_front();
          exp_rv[mp] = 1'b1;
          exp_rd.push_back('{mp, bus.iRDATA});
        end
      end
      if ((bus.oWRITE || bus.oREAD) && !bus.iWAIT_REQ) begin
        mp = bus.oGRANT[1];
        chk("grant_onehot", bus.oGRANT == 2'b01 || bus.oGRANT == 2'b10, 1);
        if (exp_cmd[mp].size() == 0) chk("cmd_unrequested", {mp, bus.oADDR}, 0);
        else begin
          c = exp_cmd[mp].pop_front();
          chk("cmd", {bus.oWRITE, bus.oADDR, bus.oWDATA}, c);
        end
        exp_ack[mp] = 1'b1;
        acc_cnt[mp]++;
        glog.push_back(mp);
        if (bus.oREAD) begin
          own_q.push_back(mp);
          rd_acc++;
        end
      end
      p_hold = (bus.oWRITE || bus.oREAD) && bus.iWAIT_REQ;
      p_snap = {bus.oWRITE, bus.oREAD, bus.oGRANT, bus.oADDR, bus.oWDATA};
    end
  end

  task automatic step;
    @(posedge iCLK);
    #2;
  endtask

  task automatic reset_dut;
    iRST_n = 0;
    step;
    iRST_n = 1;
    step;
  endtask

  task automatic issue(int p, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    int n = 0;
    req[p] = 1; wr[p] = w; addr[p] = a; wdata[p] = d;
    exp_cmd[p].push_back('{w, a, d});
    do @(negedge iCLK); while (!ack[p] && ++n < 300);
    if (!ack[p]) begin
      chk($sformatf("m%0d_ack_timeout", p), 0, 1);
      exp_cmd[p].delete();
    end
    step;
    req[p] = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, s, ret, a0;
    logic [31:0] v;
    bit done[2];
    req = '{0, 0}; wr = '{0, 0}; addr = '{'0, '0}; wdata = '{'0, '0};
    #1 iRST_n = 0;
    repeat (3) @(posedge iCLK);
    #2;
    chk("reset_outputs", {bus.oWRITE, bus.oREAD, bus.oGRANT, bus.oERR, ack, rv, bus.oADDR, bus.oWDATA}, 0);
    iRST_n = 1;
    step;
    // single write
    req[0] = 1; wr[0] = 1; addr[0] = 25'h10; wdata[0] = 16'hA5A5;
    exp_cmd[0].push_back('{1'b1, 25'h10, 16'hA5A5});
    @(negedge iCLK); chk("w_idle", bus.oWRITE, 0);
    @(negedge iCLK); chk("w_issue", {bus.oWRITE, bus.oREAD, bus.oGRANT, bus.oADDR, bus.oWDATA}, {1'b1, 1'b0, 2'b01, 25'h10, 16'hA5A5});
    @(negedge iCLK); chk("w_ack", {ack, bus.oWRITE, bus.oGRANT}, {2'b01, 1'b0, 2'b00});
    step;
    req[0] = 0;
    // stalled M1 read and its data return
    req[1] = 1; wr[1] = 0; addr[1] = 25'h1234; wdata[1] = '0; wreq = 1;
    exp_cmd[1].push_back('{1'b0, 25'h1234, 16'h0});
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      step;
      if (i == 6) wreq = 0;
      @(negedge iCLK);
      if (bus.oREAD && bus.oADDR == 25'h1234) n++;
    end
    @(negedge iCLK); chk("stall_ack", {ack, bus.oREAD}, {2'b10, 1'b0});
    chk("stall_cycles", n, 6);
    step;
    req[1] = 0; rdval = 1; rdat = 16'h5A5A;
    step;
    rdval = 0;
    @(negedge iCLK); chk("rd_route", {rv, bus.oM1_RDATA}, {2'b10, 16'h5A5A});
    // fairness: both ports stream writes
    reset_dut;
    s = glog.size();
    fork
      for (int i = 0; i < 16; i++) issue(0, 1, AW'(i), DW'($urandom));
      for (int j = 0; j < 16; j++) issue(1, 1, AW'(j + 100), DW'($urandom));
    join
    v = '0;
    for (int i = 0; i < 32 && s + i < glog.size(); i++) v[i] = glog[s + i];
    chk("fair_count", glog.size() - s, 32);
    chk("fair_order", v, 32'hFF00FF00);
    // tag FIFO full blocks a fifth M0 read but not M1 writes
    reset_dut;
    for (int i = 0; i < 4; i++) issue(0, 0, AW'(i), 16'h0);
    a0 = acc_cnt[0];
    fork
      issue(0, 0, 25'h55, 16'h0);
      begin
        issue(1, 1, 25'h77, 16'h1);
        issue(1, 1, 25'h78, 16'h2);
        chk("tag_full_block", acc_cnt[0] - a0, 0);
        rdval = 1; rdat = 16'hBEEF;
        step;
        rdval = 0;
      end
    join
    chk("tag_full_release", acc_cnt[0] - a0, 1);
    chk("tag_full_data", bus.oM0_RDATA, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      rdval = 1; rdat = DW'($urandom);
      step;
    end
    rdval = 0;
    // interleaved returns, one coinciding with a new read acceptance
    reset_dut;
    issue(0, 0, 25'h200, 16'h0);
    issue(1, 0, 25'h300, 16'h0);
    fork
      issue(0, 0, 25'h201, 16'h0);
      begin
        step; rdval = 1; rdat = 16'h1111;
        step; rdat = 16'h2222;
        step; rdat = 16'h3333;
        step; rdval = 0;
      end
    join
    @(negedge iCLK); chk("interleave_data", {bus.oM0_RDATA, bus.oM1_RDATA}, {16'h3333, 16'h2222});
    // error on empty FIFO, then reset mid-ISSUE
    reset_dut;
    rdval = 1; rdat = 16'hDEAD;
    step;
    rdval = 0;
    @(negedge iCLK); chk("err_set", {bus.oERR, rv}, {1'b1, 2'b00});
    step;
    req[0] = 1; wr[0] = 1; addr[0] = 25'h99; wdata[0] = 16'h99; wreq = 1;
    step;
    chk("rst_pre_issue", {bus.oWRITE, bus.oGRANT}, {1'b1, 2'b01});
    iRST_n = 0;
    #1;
    chk("rst_async", {bus.oWRITE, bus.oREAD, bus.oGRANT, bus.oERR, ack, rv, bus.oADDR, bus.oWDATA}, 0);
    req[0] = 0; wreq = 0;
    step;
    iRST_n = 1;
    repeat (3) begin
      @(negedge iCLK);
      chk("rst_no_ack", {ack, bus.oWRITE, bus.oERR}, 0);
    end
    // randomized traffic with random stalls and read returns
    step;
    reset_dut;
    ret = rd_acc;
    done = '{0, 0};
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) step;
          issue(0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        end
        done[0] = 1;
      end
      begin
        for (int j = 0; j < 60; j++) begin
          repeat ($urandom_range(0, 2)) step;
          issue(1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        end
        done[1] = 1;
      end
      begin
        int k = 0;
        while ((!done[0] || !done[1] || rd_acc != ret) && k < 20000) begin
          wreq = $urandom_range(0, 3) == 0;
          rdval = rd_acc != ret && $urandom_range(0, 2) == 0;
          rdat = DW'($urandom);
          if (rdval) ret++;
          step;
          k++;
        end
        wreq = 0;
        rdval = 0;
      end
    join
    repeat (3) @(negedge iCLK);
    chk("random_drain", exp_rd.size() + own_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port arbiter that shares the single SDRAM controller command port (write/read strobes, address, write data, read data) between two requesters, e.g. the SDRAM pattern tester and a second master. Sits between the requesters and the SDRAM controller. Grants round-robin with a per-grant burst limit. Tracks outstanding reads in a small owner-tag FIFO so that returned read data is steered back to the requester that issued the read.

## Interface
- ADDR_W, 25, address width
- DATA_W, 16, data width
- BURST_MAX, 8, max consecutive accepted commands for one owner while the other port is eligible (≥1)
- TAG_DEPTH, 4, outstanding-read capacity (power of 2)

- iCLK  in  1  clock; everything sampled on rising edge
- iRST_n  in  1  reset, asynchronous, active-low
- iM0_REQ, iM1_REQ  in  1  request; held high with WR/ADDR/WDATA stable until ACK
- iM0_WR, iM1_WR  in  1  1 = write, 0 = read
- iM0_ADDR, iM1_ADDR  in  ADDR_W  access address
- iM0_WDATA, iM1_WDATA  in  DATA_W  write data
- oM0_ACK, oM1_ACK  out  1  one-cycle pulse: command accepted by controller
- oM0_RDATA, oM1_RDATA  out  DATA_W  returned read data
- oM0_RVALID, oM1_RVALID  out  1  one-cycle pulse: RDATA valid
- oWRITE, oREAD  out  1  controller command strobes, never both high
- oADDR  out  ADDR_W  controller address
- oWDATA  out  DATA_W  controller write data
- iWAIT_REQ  in  1  controller stall; command accepted in a cycle where a strobe is high and iWAIT_REQ = 0
- iRDATA  in  DATA_W  controller read data
- iRDVAL  in  1  controller read data valid
- oGRANT  out  2  one-hot owner of the command in flight (bit0 = M0), 0 when idle
- oERR  out  1  sticky: iRDVAL received with tag FIFO empty

## Operation
- Eligibility: port eligible = REQ && (WR || tag_count < TAG_DEPTH).
- FSM states:
  - IDLE: all strobes low.
    - No eligible port: stay in IDLE.
    - Exactly one eligible port: grant it.
    - Both eligible: keep the last owner if burst_cnt < BURST_MAX, else grant the other port.
    - On grant: register ADDR/WDATA/WR of the owner into oADDR/oWDATA and the matching strobe; set oGRANT; go to ISSUE.
    - burst_cnt clears to 0 when the owner changes or burst_cnt = BURST_MAX.
  - ISSUE:
    - Strobe, address and data held stable while iWAIT_REQ = 1.
    - On acceptance: next cycle deassert the strobe, clear oGRANT, pulse the owner's ACK, burst_cnt += 1.
    - A read also pushes the owner ID into the tag FIFO in the acceptance cycle.
    - Go to ACKED.
  - ACKED: one dead cycle so the requester can drop or update REQ; go to IDLE.
- Tag FIFO (TAG_DEPTH × 1 bit):
  - Pop on iRDVAL.
  - Next cycle: head owner's RVALID = 1, its RDATA = registered iRDATA. The other port's RDATA holds its old value.
  - Push and pop in the same cycle are allowed; count unchanged.
  - iRDVAL while empty: no RVALID, oERR set until reset.
- Owner switching is permitted with reads outstanding; the FIFO preserves routing order.
- Asynchronous reset: state = IDLE, all strobes/ACK/RVALID/oGRANT/oERR/burst_cnt = 0, RDATA/oADDR/oWDATA = 0, FIFO emptied, last owner = M1 (so M0 wins the first tie).
- Reset mid-ISSUE: the command is dropped with no ACK; the requester must re-request.

## Timing
- REQ high at edge T0 (arbiter in IDLE): strobe high in cycle T0+1.
- With iWAIT_REQ = 0, ACK high in cycle T0+2. Each stall cycle adds 1.
- Minimum 3 cycles per command; a port is re-grantable in the cycle after ACKED.
- Read-data latency through the arbiter: 1 cycle (iRDVAL at T → RVALID at T+1).
- ACK and RVALID are registered single-cycle pulses. ACK and RVALID of the same port may coincide.
- The strobe never drops before acceptance. oADDR/oWDATA change only in IDLE.

## Test plan
- Single write: M0 REQ, WR = 1, ADDR = 0x0000010, WDATA = 0xA5A5, iWAIT_REQ = 0 → oWRITE high exactly 1 cycle with those values, oM0_ACK 2 cycles after REQ, oGRANT = 01 during ISSUE.
- Stall: M1 read ADDR = 0x0001234, iWAIT_REQ high 5 cycles → oREAD and oADDR stable 6 cycles, oM1_ACK 1 cycle after iWAIT_REQ falls. iRDVAL with iRDATA = 0x5A5A → oM1_RVALID and oM1_RDATA = 0x5A5A next cycle.
- Fairness: both ports stream writes continuously, BURST_MAX = 8 → grants alternate in runs of 8 (M0 first), and no port is starved.
- Tag full: M0 issues 4 reads with no iRDVAL → 5th M0 read not granted while M1 writes proceed. One iRDVAL → M0 routed its data, 5th read then granted.
- Interleaved returns: reads accepted M0, M1, M0 → three iRDVAL pulses (including one coinciding with a new read acceptance) yield RVALID on M0, M1, M0 in order.
- Error/reset: iRDVAL with FIFO empty → oERR = 1, no RVALID. iRST_n low mid-ISSUE → all outputs 0 immediately, no ACK, oERR cleared.
